aes_encrypt_seq: RTL and testbench

AES_ENCRYPT_SEQ -- requirements
Module: aes_encrypt_seq

---
 rtl/aes_encrypt_seq_pkg.sv | 26 ++
 rtl/aes_sbox_fwd.sv | 29 ++
 rtl/aes_encrypt_seq.sv | 133 +++++++++++++
 tb/tb_aes_encrypt_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_encrypt_seq_pkg.sv
// Shared definitions for the iterative AES-128 encryption core:
// FSM state type, round count, block width and the key-schedule round constants.
package aes_encrypt_seq_pkg;

  localparam int         BLOCK_W = 128;
  localparam logic [3:0] NR      = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // Rcon for rounds 1..10 (index 0 holds round 1)
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] rcon_for(input logic [3:0] round);
    rcon_for = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (round == 4'(i + 1)) rcon_for = RCON[i];
    end
  endfunction

endpackage

// File: rtl/aes_sbox_fwd.sv
// Forward AES S-box, one byte in, one byte out, purely combinational lookup.
module aes_sbox_fwd (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Row-major table: entry 0 is the leftmost byte
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  assign o_byte = SBOX_TABLE[i_byte];

endmodule

// File: rtl/aes_encrypt_seq.sv
// Iterative AES-128 encryption core: one round per clock, round keys derived on the fly
// from the previous round key, valid/ready handshakes on both sides.
module aes_encrypt_seq
  import aes_encrypt_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [BLOCK_W-1:0] key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] ciphertext
);

  aes_state_e         r_fsm;
  logic [BLOCK_W-1:0] r_state;
  logic [BLOCK_W-1:0] r_rkey;
  logic [3:0]         r_round;

  logic [BLOCK_W-1:0] w_sub_state;
  logic [BLOCK_W-1:0] w_shifted;
  logic [BLOCK_W-1:0] w_rkey_next;
  logic [BLOCK_W-1:0] w_round_out;
  logic [31:0]        w_rot_word;
  logic [31:0]        w_sub_word;

  // Byte b of the state sits at [127-8b -: 8], b = 4*column + row
  function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // sub_word is SubWord(RotWord(w3)) of the current key, computed by the key S-boxes
  function automatic logic [BLOCK_W-1:0] key_expand(input logic [BLOCK_W-1:0] rk,
                                                    input logic [31:0] sub_word,
                                                    input logic [7:0] rcon);
    logic [31:0] n0, n1, n2, n3;
    n0 = rk[127:96] ^ sub_word ^ {rcon, 24'h000000};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_state_sbox
      aes_sbox_fwd u_sbox (
        .i_byte (r_state[BLOCK_W-1-8*gi -: 8]),
        .o_byte (w_sub_state[BLOCK_W-1-8*gi -: 8])
      );
    end
    for (gi = 0; gi < 4; gi++) begin : g_key_sbox
      aes_sbox_fwd u_sbox (
        .i_byte (w_rot_word[31-8*gi -: 8]),
        .o_byte (w_sub_word[31-8*gi -: 8])
      );
    end
  endgenerate

  assign w_rot_word  = {r_rkey[23:0], r_rkey[31:24]};
  assign w_rkey_next = key_expand(r_rkey, w_sub_word, rcon_for(r_round));
  assign w_shifted   = shift_rows(w_sub_state);
  assign w_round_out = ((r_round == NR) ? w_shifted : mix_columns(w_shifted)) ^ w_rkey_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_rkey  <= '0;
      r_round <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state <= plaintext ^ key;
            r_rkey  <= key;
            r_round <= 4'd1;
            r_fsm   <= RUN;
          end
        end
        RUN: begin
          r_state <= w_round_out;
          r_rkey  <= w_rkey_next;
          r_round <= r_round + 4'd1;
          if (r_round == NR) r_fsm <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_round <= '0;
            r_fsm   <= IDLE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_fsm == IDLE);
  assign out_valid  = (r_fsm == DONE);
  assign ciphertext = r_state;

endmodule

// File: tb/tb_aes_encrypt_seq.sv
// Scoreboard bench for aes_encrypt_seq: directed FIPS-197 vectors, backpressure, busy input,
// mid-run reset and a random back-to-back run checked against an independent byte-level model.
module tb_aes_encrypt_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] ciphertext;

  aes_encrypt_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct {
    logic [127:0] exp;
    time          t_acc;
    string        tag;
  } sb_entry_t;

  sb_entry_t  sb_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  bit         rand_ready = 1'b0;
  logic [7:0] sbox_m [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b, required %b", name, act, req);
  endtask

  // ---------------- reference model (GF arithmetic, full key expansion) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- driver helpers (called at posedge+1) ----------------
  task automatic send(input logic [127:0] pt, input logic [127:0] k,
                      input logic [127:0] exp, input string tag);
    int waited;
    waited = 0;
    plaintext = pt; key = k; in_valid = 1'b1;
    while (!in_ready && waited < 300) begin
      @(posedge clk); #1; waited++;
    end
    check_bit({tag, " accept_ready"}, in_ready, 1'b1);
    @(posedge clk);
    sb_q.push_back('{exp, $time, tag});
    #1;
    in_valid  = 1'b0;
    plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
    key       = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check({name, " drain"}, 128'(sb_q.size()), 128'd0);
  endtask

  // ---------------- monitor: latency on rise, data on handshake ----------------
  initial begin : monitor
    bit        prev_valid;
    sb_entry_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          if (sb_q.size() == 0) check_bit("unexpected out_valid", out_valid, 1'b0);
          else check({sb_q[0].tag, " latency"}, 128'($time - sb_q[0].t_acc), 128'd105);
        end
        if (out_valid && out_ready && sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check({e.tag, " ciphertext"}, ciphertext, e.exp);
          $display("blk %-10s ct=%h exp=%h", e.tag, ciphertext, e.exp);
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int           n;
    int           gap;
    logic [7:0]   inv, b;
    logic [127:0] pt_r, key_r;

    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      b = inv;
      sbox_m[a] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset out_valid", out_valid, 1'b0);
    check("reset ciphertext", ciphertext, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_bit("reset in_ready", in_ready, 1'b1);
    check_bit("reset out_valid released", out_valid, 1'b0);

    out_ready = 1'b1;
    send(PT1, KEY1, CT1, "fips_c1");
    wait_drain("fips_c1");
    send(PT2, KEY2, CT2, "fips_b");
    wait_drain("fips_b");
    send(128'd0, 128'd0, CT0, "zero");
    wait_drain("zero");

    // backpressure: DONE held for 20 cycles
    out_ready = 1'b0;
    send(PT2, KEY2, CT2, "bp");
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 20; i++) begin
      check_bit("bp out_valid", out_valid, 1'b1);
      check_bit("bp in_ready", in_ready, 1'b0);
      check("bp ciphertext", ciphertext, CT2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_bit("bp in_ready after release", in_ready, 1'b1);
    check_bit("bp out_valid after release", out_valid, 1'b0);

    // busy: input toggles while rounds run
    send(PT1, KEY1, CT1, "busy");
    for (int i = 0; i < 8; i++) begin
      check_bit("busy in_ready", in_ready, 1'b0);
      in_valid  = i[0];
      plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
      key       = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain("busy");
    repeat (14) @(posedge clk);
    #1;
    check_bit("busy no extra block", out_valid, 1'b0);

    // reset in the middle of round 5
    send(PT1, KEY1, CT1, "abort");
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("abort out_valid", out_valid, 1'b0);
    check("abort ciphertext", ciphertext, 128'd0);
    check_bit("abort in_ready", in_ready, 1'b1);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(PT1, KEY1, CT1, "post_rst");
    wait_drain("post_rst");

    // random back-to-back with gaps on both sides
    rand_ready = 1'b1;
    for (int v = 0; v < 100; v++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      pt_r  = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_r = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(pt_r, key_r, aes_ref(pt_r, key_r), $sformatf("rnd%0d", v));
    end
    wait_drain("random");
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
